pipelined_cla_adder: RTL
========================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the fixed-width CLA adder.
//  WIDTH-bit operands split into STAGES equal slices, one slice per pipeline stage.
//  Inter-slice carry is registered; each slice resolves internally with GROUP-bit lookahead.
//  Valid/ready on input and output; sits between operand-issue logic and the result writeback path.
// PARAMETERS
//  WIDTH   32  operand/result width; WIDTH % STAGES == 0
//  STAGES  2   pipeline depth = latency in cycles; SW = WIDTH/STAGES bits per stage; 1 <= STAGES <= WIDTH
//  GROUP   4   lookahead group size inside a slice; SW % GROUP == 0
// PORTS
//  clock          in   1      sole clock, rising edge
//  reset          in   1      synchronous, active-high
//  io_in_valid    in   1      operand beat valid
//  io_in_ready    out  1      operand beat accepted when valid&ready
//  io_in_a        in   WIDTH  operand A
//  io_in_b        in   WIDTH  operand B
//  io_in_c_in     in   1      carry-in (add) / borrow-in (sub)
//  io_in_sub      in   1      0: A+B+c_in; 1: A-B-c_in
//  io_out_valid   out  1      result valid
//  io_out_ready   in   1      downstream accepts result
//  io_out_s       out  WIDTH  sum/difference, mod 2^WIDTH
//  io_out_c_out   out  1      carry-out (add); NOT-borrow (sub)
//  io_out_ovf     out  1      signed overflow
// BEHAVIOUR
//  - Reset: all stage valid bits, io_out_valid, io_out_s, io_out_c_out, io_out_ovf = 0. Reset wins over any fire; in-flight beats are discarded.
//  - Operand prep at entry: b_eff = io_in_sub ? ~io_in_b : io_in_b; cin_eff = io_in_c_in ^ io_in_sub.
//  - Stage k (0..STAGES-1) adds slice [k*SW +: SW] of a and b_eff with the carry registered by stage k-1 (stage 0: cin_eff).
//    It registers: its sum slice, the carry-out of the slice, and the carry into the slice MSB (for ovf on the last stage).
//  - Unconsumed upper operand slices and completed lower sum slices travel with the beat (skew/deskew registers).
//  - The last stage's registers are the outputs. io_out_c_out = carry out of bit WIDTH-1.
//    io_out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//  - Latency: beat accepted in cycle t -> io_out_valid in cycle t+STAGES if no stall. Throughput 1 beat/cycle.
//  - Flow control, global stall: adv = !io_out_valid | io_out_ready.
//    io_in_ready = adv, a combinational path from io_out_ready. All stage registers load only when adv.
//    Stage-0 valid loads io_in_valid & adv.
//  - Stall: while !adv, every stage register holds (valid and data). io_out_* stay stable while io_out_valid & !io_out_ready.
//  - Bubbles are not collapsed. A stage with valid=0 advances as an empty slot; its data registers may update.
//  - No operand constraint: all-ones + all-ones + 1 yields s = all-ones, c_out = 1.
//  - Sub mode: A - B - c_in. Borrow out is reported as io_out_c_out = 0.
//  - STAGES == 1 degenerates to one registered WIDTH-bit CLA, latency 1.
//  - Per-beat sub flag is carried only to the operand-prep point; later stages need no mode.
// STRUCTURE
//  - Package pipelined_cla_pkg: localparam SW; stage struct typedef {valid, a_hi, b_hi, s_lo, carry, msb_cin}.
//    Also holds the elaboration checks on WIDTH/STAGES/GROUP.
//  - Sub-module cla_slice #(SW, GROUP): combinational; inputs a, b, c_in; outputs s, c_out, c_msb.
//    Two-level lookahead: per-bit p = a|b, g = a&b feed per-group CLA, then group p/g feed slice-level CLA.
//    Instantiate STAGES times via generate.
//  - Top holds the pipeline registers and the adv/valid chain only.
// TESTING (WIDTH=8, STAGES=2, GROUP=2 unless stated)
//  1. a=0xFF b=0x01 c_in=0 sub=0, out_ready=1 -> 2 cycles later: s=0x00 c_out=1 ovf=0; then out_valid drops.
//  2. a=0x7F b=0x01 add -> s=0x80 c_out=0 ovf=1. a=0x80 b=0x80 -> s=0x00 c_out=1 ovf=1.
//  3. sub=1: a=0x05 b=0x07 c_in=0 -> s=0xFE c_out=0 ovf=0. a=0x80 b=0x01 c_in=1 -> s=0x7E c_out=1 ovf=1.
//  4. Back-to-back: 16 random beats, in_valid held high, out_ready=1.
//     Requirements: in_ready constantly 1, out_valid high cycles 2..17, every result matches the reference model in order.
//  5. Backpressure: stream 6 beats, out_ready=0 for cycles 3-5.
//     Requirements: in_ready=0 during the stall, outputs stable, no beat lost or duplicated, order preserved.
//  6. Reset mid-flight: 2 beats accepted, reset high 1 cycle before either emerges.
//     Requirements: out_valid=0 the cycle after reset, no stale beat ever appears. Repeat with STAGES=1 and STAGES=4 (WIDTH=16).

Source files
------------

// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// default geometry, per-stage control flags and parameter sanity helpers.
package pipelined_cla_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 2;
  localparam int DEFAULT_GROUP  = 4;
  localparam int SW             = DEFAULT_WIDTH / DEFAULT_STAGES;

  // Control bits that every stage hands to the next one along with its data.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_flags_t;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit params_ok(input int width, input int stages, input int group);
    if (stages < 1 || stages > width) return 1'b0;
    if (width % stages != 0) return 1'b0;
    if (group < 1) return 1'b0;
    return ((width / stages) % group) == 0;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_slice.sv
// Combinational SW-bit adder slice with two-level carry lookahead:
// bit p/g resolve inside GROUP-bit groups, group p/g resolve across the slice.
module cla_slice #(
  parameter int SW    = 16,
  parameter int GROUP = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          c_in,
  output logic [SW-1:0] s,
  output logic          c_out,
  output logic          c_msb
);

  localparam int NG = SW / GROUP;

  logic [SW-1:0] p;
  logic [SW-1:0] g;
  logic [SW-1:0] c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   cg;

  assign p = a | b;
  assign g = a & b;

  always_comb begin
    gg = '0;
    gp = '1;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    end
  end

  // Every carry is expanded as a sum of products back to the nearest known
  // carry, so no carry waits on its neighbour within a level.
  always_comb begin
    logic run;
    run = 1'b1;
    cg  = '0;
    c   = '0;
    for (int j = 0; j <= NG; j++) begin
      run = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        cg[j] = cg[j] | (run & gg[m]);
        run   = run & gp[m];
      end
      cg[j] = cg[j] | (run & c_in);
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < GROUP; i++) begin
        run = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          c[j*GROUP+i] = c[j*GROUP+i] | (run & g[j*GROUP+m]);
          run          = run & p[j*GROUP+m];
        end
        c[j*GROUP+i] = c[j*GROUP+i] | (run & cg[j]);
      end
    end
  end

  assign s     = a ^ b ^ c;
  assign c_out = cg[NG];
  assign c_msb = c[SW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CLA slice per stage, registered
// inter-slice carry, global stall driven by the output handshake.
module pipelined_cla_adder
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_c_in,
  input  logic             io_in_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_s,
  output logic             io_out_c_out,
  output logic             io_out_ovf
);

  localparam int SLICE_W = slice_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES, GROUP)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH/STAGES/GROUP do not split into whole slices and groups");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv         = !io_out_valid || io_out_ready;
  assign io_in_ready = adv;
  assign b_eff       = io_in_sub ? ~io_in_b : io_in_b;
  assign cin_eff     = io_in_c_in ^ io_in_sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SLICE_W;
    localparam int LO_W  = (k + 1) * SLICE_W;

    logic [SRC_W-1:0]   src_a;
    logic [SRC_W-1:0]   src_b;
    logic               src_valid;
    logic               src_carry;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               slice_cmsb;
    logic [LO_W-1:0]    next_s_lo;
    logic [LO_W-1:0]    s_lo;
    stage_flags_t       flags;

    if (k == 0) begin : g_entry
      assign src_a     = io_in_a;
      assign src_b     = b_eff;
      assign src_valid = io_in_valid;
      assign src_carry = cin_eff;
      assign next_s_lo = slice_s;
    end else begin : g_chain
      assign src_a     = g_stage[k-1].g_fwd.a_hi;
      assign src_b     = g_stage[k-1].g_fwd.b_hi;
      assign src_valid = g_stage[k-1].flags.valid;
      assign src_carry = g_stage[k-1].flags.carry;
      assign next_s_lo = {slice_s, g_stage[k-1].s_lo};
    end

    cla_slice #(
      .SW    (SLICE_W),
      .GROUP (GROUP)
    ) u_slice (
      .a     (src_a[SLICE_W-1:0]),
      .b     (src_b[SLICE_W-1:0]),
      .c_in  (src_carry),
      .s     (slice_s),
      .c_out (slice_cout),
      .c_msb (slice_cmsb)
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        flags <= '0;
        s_lo  <= '0;
      end else if (adv) begin
        flags.valid <= src_valid;
        flags.carry <= slice_cout;
        s_lo        <= next_s_lo;
      end
    end

    // Upper operand bits ride along until their own stage consumes them;
    // only the final stage needs the carry into the result MSB.
    if (k < STAGES - 1) begin : g_fwd
      logic [SRC_W-SLICE_W-1:0] a_hi;
      logic [SRC_W-SLICE_W-1:0] b_hi;
      logic                     cmsb_unused;

      assign cmsb_unused = slice_cmsb;

      always_ff @(posedge clock) begin
        if (reset) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (adv) begin
          a_hi <= src_a[SRC_W-1:SLICE_W];
          b_hi <= src_b[SRC_W-1:SLICE_W];
        end
      end
    end else begin : g_last
      logic msb_cin;

      always_ff @(posedge clock) begin
        if (reset) begin
          msb_cin <= 1'b0;
        end else if (adv) begin
          msb_cin <= slice_cmsb;
        end
      end
    end
  end

  assign io_out_valid = g_stage[STAGES-1].flags.valid;
  assign io_out_s     = g_stage[STAGES-1].s_lo;
  assign io_out_c_out = g_stage[STAGES-1].flags.carry;
  assign io_out_ovf   = g_stage[STAGES-1].g_last.msb_cin ^ g_stage[STAGES-1].flags.carry;

endmodule
